// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key scanner: bank width, debounce count
// width, debounce FSM states and the lowest-set-bit helper.
package piano_pkg;

    localparam int BANK_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } deb_state_t;

    // Two's-complement trick: v & -v isolates the lowest set bit (0 when v is 0).
    function automatic logic [BANK_W-1:0] lowest_set(input logic [BANK_W-1:0] v);
        return v & (~v + BANK_W'(1));
    endfunction

endpackage

// File: rtl/key_bank_debounce.sv
// One key bank: STABLE/SETTLING debounce on the shared sample tick, then a registered
// lowest-index one-hot note. Define PIANO_KEY_HOLD_EN to hold the note on all-keys-up.
module key_bank_debounce
    import piano_pkg::*;
#(
    parameter int STABLE_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [BANK_W-1:0] key_sync,
    output logic [BANK_W-1:0] sensor_data,
    output logic              data_change,
    output logic              settling
);

    // Entry tick is count 0; acceptance happens on the tick that brings the count to STABLE_N-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_N - 2);

    deb_state_t        state, state_nxt;
    logic [BANK_W-1:0] cand, cand_nxt;
    logic [BANK_W-1:0] acc, acc_nxt;
    logic [BANK_W-1:0] sensor_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_STABLE;
            cand        <= '0;
            acc         <= '0;
            cnt         <= '0;
            sensor_data <= '0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            sensor_data <= sensor_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            ST_STABLE: begin
                if (tick && (key_sync != acc)) begin
                    cand_nxt  = key_sync;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (tick) begin
                    if (key_sync != cand) begin
                        cand_nxt = key_sync;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            acc_nxt   = cand;
                            state_nxt = ST_STABLE;
                        end
                    end
                end
            end
            default: state_nxt = ST_STABLE;
        endcase
    end

    always_comb begin
`ifdef PIANO_KEY_HOLD_EN
        sensor_nxt = (acc == '0) ? sensor_data : lowest_set(acc);
`else
        sensor_nxt = lowest_set(acc);
`endif
    end

    // Reported in the same cycle sensor_nxt differs, so the top registers the pulse
    // on the same edge that sensor_data takes its new value.
    assign data_change = (sensor_nxt != sensor_data);
    assign settling    = (state == ST_SETTLING);

endmodule

// File: rtl/piano_key_scan.sv
// Two 8-key banks: 2-flop synchronisers, shared sample prescaler, per-bank debounce and
// lowest-index note, plus a one-cycle note_change pulse. Option macro: PIANO_KEY_HOLD_EN.
module piano_key_scan
    import piano_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int SAMPLE_HZ = 1000,
    parameter int STABLE_N  = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [BANK_W-1:0] key_raw_1,
    input  logic [BANK_W-1:0] key_raw_2,
    output logic [BANK_W-1:0] sensor_data_1,
    output logic [BANK_W-1:0] sensor_data_2,
    output logic              note_change,
    output logic [1:0]        bank_state
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [BANK_W-1:0] sync1_1, sync2_1, sync1_2, sync2_2;
    logic              chg_1, chg_2;
    logic              settling_1, settling_2;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_1 <= '0;
            sync2_1 <= '0;
            sync1_2 <= '0;
            sync2_2 <= '0;
        end else begin
            sync1_1 <= key_raw_1;
            sync2_1 <= sync1_1;
            sync1_2 <= key_raw_2;
            sync2_2 <= sync1_2;
        end
    end

    assign tick = (pre_cnt == PRE_W'(DIV - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    key_bank_debounce #(.STABLE_N(STABLE_N)) u_bank_1 (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .tick        (tick),
        .key_sync    (sync2_1),
        .sensor_data (sensor_data_1),
        .data_change (chg_1),
        .settling    (settling_1)
    );

    key_bank_debounce #(.STABLE_N(STABLE_N)) u_bank_2 (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .tick        (tick),
        .key_sync    (sync2_2),
        .sensor_data (sensor_data_2),
        .data_change (chg_2),
        .settling    (settling_2)
    );

    // One pulse even when both banks change on the same edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            note_change <= 1'b0;
        end else begin
            note_change <= chg_1 | chg_2;
        end
    end

    assign bank_state = {settling_2, settling_1};

endmodule

// File: tb/tb_piano_key_scan.sv
// Bench for piano_key_scan: directed scenarios plus random key traffic, checked by a
// scoreboard fed from a sample-level "N equal samples in a row" reference model.
module tb_piano_key_scan;

    localparam int CLK_HZ    = 1000;
    localparam int SAMPLE_HZ = 100;
    localparam int STABLE_N  = 4;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int W         = 48;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_raw_1 = 8'h00;
    logic [7:0] key_raw_2 = 8'h00;
    logic [7:0] sensor_data_1, sensor_data_2;
    logic       note_change;
    logic [1:0] bank_state;

    always #5 clk = ~clk;

    piano_key_scan #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .STABLE_N  (STABLE_N)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .key_raw_1     (key_raw_1),
        .key_raw_2     (key_raw_2),
        .sensor_data_1 (sensor_data_1),
        .sensor_data_2 (sensor_data_2),
        .note_change   (note_change),
        .bank_state    (bank_state)
    );

    // Expected output events: {cycle, sensor_data_1, sensor_data_2}
    logic [W-1:0] exp_q[$];

    int         checks = 0;
    int         passed = 0;
    int         pulses = 0;
    int         n = 0;
    logic [7:0] h1[$];
    logic [7:0] h2[$];
    logic [7:0] acc[2];
    logic [7:0] last_s[2];
    logic [7:0] m_sd[2];
    int         run_len[2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 8'(1 << i);
        end
        return 8'h00;
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        n = 0;
        h1.delete();
        h2.delete();
        exp_q.delete();
        for (int b = 0; b < 2; b++) begin
            acc[b]     = 8'h00;
            last_s[b]  = 8'h00;
            m_sd[b]    = 8'h00;
            run_len[b] = 0;
        end
    endtask

    task automatic model_step();
        logic [7:0] s[2];
        logic [7:0] nsd[2];
        n++;
        h1.push_back(key_raw_1);
        h2.push_back(key_raw_2);
        if (n % DIV == 0) begin
            // Synchronised view at edge n is the raw value present at edge n-2.
            s[0] = (n >= 3) ? h1[n-3] : 8'h00;
            s[1] = (n >= 3) ? h2[n-3] : 8'h00;
            for (int b = 0; b < 2; b++) begin
                if (run_len[b] > 0 && s[b] == last_s[b]) run_len[b]++;
                else run_len[b] = 1;
                last_s[b] = s[b];
                if (run_len[b] == STABLE_N && s[b] != acc[b]) acc[b] = s[b];
                nsd[b] = m_sd[b];
`ifdef PIANO_KEY_HOLD_EN
                if (acc[b] != 8'h00) nsd[b] = lowest_bit(acc[b]);
`else
                nsd[b] = lowest_bit(acc[b]);
`endif
            end
            if (nsd[0] != m_sd[0] || nsd[1] != m_sd[1]) begin
                exp_q.push_back({32'(n + 1), nsd[0], nsd[1]});
                m_sd[0] = nsd[0];
                m_sd[1] = nsd[1];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [7:0] last1, last2;
        last1 = 8'h00;
        last2 = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && (note_change || sensor_data_1 !== last1 || sensor_data_2 !== last2)) begin
                if (note_change) pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_event: got sd1=0x%0h sd2=0x%0h note=%0b at cycle %0d, required no event",
                             sensor_data_1, sensor_data_2, note_change, n);
                end else begin
                    check("event", {32'(n), sensor_data_1, sensor_data_2}, exp_q.pop_front());
                    check("event_pulse", W'(note_change), W'(1));
                end
            end
            last1 = sensor_data_1;
            last2 = sensor_data_2;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int p0;
        int hold;

        wait_cycles(3);
        check("reset_sd1", W'(sensor_data_1), W'(0));
        check("reset_sd2", W'(sensor_data_2), W'(0));
        check("reset_note", W'(note_change), W'(0));
        check("reset_state", W'(bank_state), W'(0));
        rst_n = 1'b1;

        // Single key press on bank 1
        p0 = pulses;
        key_raw_1 = 8'h04;
        wait_cycles(2 + (STABLE_N + 1) * DIV + 1);
        check("press_sd1", W'(sensor_data_1), W'(8'h04));
        check("press_sd2", W'(sensor_data_2), W'(8'h00));
        check("press_pulses", W'(pulses - p0), W'(1));
        check("press_drained", W'(exp_q.size()), W'(0));

        // 3-cycle glitch on bank 2 falling between ticks
        for (int i = 0; i < DIV && (n % DIV) != 1; i++) @(negedge clk);
        p0 = pulses;
        key_raw_2 = 8'h10;
        wait_cycles(3);
        key_raw_2 = 8'h00;
        wait_cycles(60);
        check("glitch_sd2", W'(sensor_data_2), W'(8'h00));
        check("glitch_pulses", W'(pulses - p0), W'(0));

        // Settling restart: 01 for two ticks then 03 held
        p0 = pulses;
        key_raw_1 = 8'h01;
        wait_cycles(2 * DIV);
        key_raw_1 = 8'h03;
        wait_cycles(60);
        check("restart_sd1", W'(sensor_data_1), W'(8'h01));
        check("restart_pulses", W'(pulses - p0), W'(1));

        // Both banks change together
        p0 = pulses;
        key_raw_1 = 8'h80;
        key_raw_2 = 8'h02;
        wait_cycles(60);
        check("both_sd1", W'(sensor_data_1), W'(8'h80));
        check("both_sd2", W'(sensor_data_2), W'(8'h02));
        check("both_pulses", W'(pulses - p0), W'(1));

        // Release bank 1
        p0 = pulses;
        key_raw_1 = 8'h00;
        wait_cycles(60);
`ifdef PIANO_KEY_HOLD_EN
        check("release_sd1", W'(sensor_data_1), W'(8'h80));
        check("release_pulses", W'(pulses - p0), W'(0));
`else
        check("release_sd1", W'(sensor_data_1), W'(8'h00));
        check("release_pulses", W'(pulses - p0), W'(1));
`endif

        // Reset during settling, then full re-acceptance with inputs unchanged
        key_raw_1 = 8'h20;
        wait_cycles(25);
        check("settling_state", W'(bank_state[0]), W'(1));
        rst_n = 1'b0;
        #1;
        check("midreset_sd1", W'(sensor_data_1), W'(0));
        check("midreset_sd2", W'(sensor_data_2), W'(0));
        check("midreset_note", W'(note_change), W'(0));
        check("midreset_state", W'(bank_state), W'(0));
        wait_cycles(2);
        rst_n = 1'b1;
        p0 = pulses;
        wait_cycles(STABLE_N * DIV);
        check("reaccept_early_sd1", W'(sensor_data_1), W'(0));
        wait_cycles(1);
        check("reaccept_sd1", W'(sensor_data_1), W'(8'h20));
        check("reaccept_sd2", W'(sensor_data_2), W'(8'h02));
        check("reaccept_note", W'(note_change), W'(1));
        check("reaccept_pulses", W'(pulses - p0), W'(1));

        // Random key traffic, short glitches and long holds mixed
        for (int it = 0; it < 30; it++) begin
            key_raw_1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            key_raw_2 = ($urandom_range(0, 3) == 0) ? key_raw_2 : 8'($urandom_range(0, 255));
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 70);
            wait_cycles(hold);
        end
        wait_cycles(70);
        check("final_sd1", W'(sensor_data_1), W'(m_sd[0]));
        check("final_sd2", W'(sensor_data_2), W'(m_sd[1]));
        check("final_drained", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/piano_key_scan.md
PIANO_KEY_SCAN -- requirements
Module: piano_key_scan

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_HZ, default 1000, key sampling rate in Hz; CLK_HZ/SAMPLE_HZ SHALL be an integer >= 2.
REQ-003 SHALL have parameter STABLE_N, default 4, consecutive equal samples needed to accept a bank value; range 2..15.
REQ-004 SHALL have port clk_in  input  1  system clock; the block uses this single clock only.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port key_raw_1  input  8  raw key bank 1, active-high, asynchronous to clk_in.
REQ-007 SHALL have port key_raw_2  input  8  raw key bank 2, active-high, asynchronous to clk_in.
REQ-008 SHALL have port sensor_data_1  output  8  bank 1 note, one-hot or all-zero, for the downstream segment display.
REQ-009 SHALL have port sensor_data_2  output  8  bank 2 note, same encoding.
REQ-010 SHALL have port note_change  output  1  one-cycle pulse when either sensor_data output changes.

Function
REQ-011 SHALL pass each raw bank through a 2-flop synchroniser before any other use.
REQ-012 SHALL run a prescaler counting 0..CLK_HZ/SAMPLE_HZ-1, wrapping to 0 and asserting an internal tick on the terminal count.
REQ-013 SHALL run an independent two-state debounce FSM per bank: STABLE and SETTLING.
REQ-014 On a tick in STABLE, a synced value unequal to the accepted value SHALL load the candidate, clear the count, and enter SETTLING.
REQ-015 On a tick in SETTLING, a synced value unequal to the candidate SHALL reload the candidate and clear the count, staying in SETTLING.
REQ-016 On a tick in SETTLING, a synced value equal to the candidate SHALL increment the count. When the count reaches STABLE_N-1, the accepted value SHALL take the candidate and the FSM SHALL return to STABLE.
REQ-017 A candidate equal to the accepted value on acceptance SHALL be accepted silently and SHALL cause no output change.
REQ-018 Between ticks the FSM SHALL hold; input glitches shorter than one sample period SHALL have no effect.
REQ-019 Each sensor_data output SHALL be registered as the lowest-index set bit of its accepted value, or 8'h00 if none is set. Multiple pressed keys SHALL therefore resolve to the lowest index.
REQ-020 Each sensor_data output SHALL update exactly one clk_in cycle after its accepted value changes.
REQ-021 note_change SHALL pulse high for exactly one cycle, in the cycle after any sensor_data value changes. Simultaneous changes on both banks SHALL produce one pulse.
REQ-022 Worst-case latency from a stable raw change to the output SHALL be 2 cycles, plus (STABLE_N+1) sample periods, plus 1 cycle.

Reset
REQ-023 Assertion of rst_n_in SHALL immediately clear the synchronisers, prescaler, FSMs (to STABLE), candidates, counts, accepted values, sensor_data_1/2 (8'h00) and note_change (0).
REQ-024 Reset asserted mid-settling SHALL discard the pending candidate. After release, no note_change SHALL occur until a new value is accepted.

Configuration
REQ-025 With macro PIANO_KEY_HOLD_EN defined, an accepted all-zero value SHALL leave sensor_data unchanged, so the last note is held until another key is accepted. Reset SHALL still clear sensor_data.
REQ-026 Without PIANO_KEY_HOLD_EN, an accepted all-zero value SHALL drive sensor_data to 8'h00 with a note_change pulse.

Structure
REQ-027 A shared package piano_pkg SHALL hold the debounce FSM state enum, the bank width constant (8) and the count width constant (4).
REQ-028 Per-bank debounce and one-hot logic SHALL be one sub-module, key_bank_debounce, instantiated twice and sharing the top-level prescaler tick.

Verification (bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 giving 10 cycles per tick, STABLE_N=4)
REQ-029 Press key_raw_1=8'h04 and hold -> sensor_data_1=8'h04 and one note_change pulse, within 2+50+1 cycles; sensor_data_2 stays 8'h00.
REQ-030 A 3-cycle glitch key_raw_2=8'h10 between ticks -> sensor_data_2 stays 8'h00 and no note_change pulse.
REQ-031 key_raw_1 goes 8'h01, then to 8'h03 after 2 ticks, then held -> SETTLING restarts; final sensor_data_1=8'h01 (lowest index) with exactly one pulse.
REQ-032 Both banks change on the same tick (8'h80, 8'h02) -> both outputs update in the same cycle with a single note_change pulse.
REQ-033 Release to 8'h00 -> without PIANO_KEY_HOLD_EN, output 8'h00 plus a pulse; with it defined, output stays 8'h80 and no pulse.
REQ-034 Reset asserted during SETTLING -> all outputs 0 immediately; after release with raw inputs unchanged, re-acceptance follows the full STABLE_N sequence.
